// File: rtl/hitmap_lcmap_pipe.sv
// -----------------------------------------------------------------------------
// hitmap_lcmap_pipe
//
// Delay pipeline for hitmap/lcmap words between road/hit fetch and the fit
// stage. NSTAGE register stages hold {hitmap, lcmap}. Stage 0 captures on ce.
// Stage k captures CE_DELAY cycles after stage k-1, timed by a shared enable
// delay line. The block also raises an output-valid pulse, supports a
// synchronous flush and flags (sticky) strobes that arrive too close together.
//
// Parameters
//   NLAYER   : width of the hitmap and lcmap words (one bit per layer)
//   NSTAGE   : number of register stages, 1..8
//   CE_DELAY : cycles between captures at successive stages, 1..16
//
// Ports
//   clock      in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   ce         in   capture strobe for stage 0
//   flush      in   synchronous clear of stages, delay line and flags
//   hitmap_in  in   hitmap word, sampled when ce=1
//   lcmap_in   in   lcmap word, sampled when ce=1
//   hitmap_out out  final-stage hitmap
//   lcmap_out  out  final-stage lcmap
//   out_valid  out  one-cycle pulse: final stage holds a newly captured word
//   overrun    out  sticky: ce came less than CE_DELAY cycles after the last ce
// -----------------------------------------------------------------------------
module hitmap_lcmap_pipe #(
    parameter int NLAYER   = 5,
    parameter int NSTAGE   = 2,
    parameter int CE_DELAY = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ce,
    input  logic              flush,
    input  logic [NLAYER-1:0] hitmap_in,
    input  logic [NLAYER-1:0] lcmap_in,
    output logic [NLAYER-1:0] hitmap_out,
    output logic [NLAYER-1:0] lcmap_out,
    output logic              out_valid,
    output logic              overrun
);

    localparam int W      = 2 * NLAYER;
    localparam int DL_LEN = (NSTAGE - 1) * CE_DELAY;
    // Keep the delay-line vector at least one bit wide so the single-stage
    // build still elaborates; it is tied to zero in that case.
    localparam int DL_W   = (DL_LEN > 0) ? DL_LEN : 1;

    logic [W-1:0]      r_stage [NSTAGE];
    logic [DL_W-1:0]   r_dl;
    logic [NSTAGE-1:0] w_en;
    logic              w_recent;
    logic              r_out_valid;
    logic              r_overrun;

    // Per-stage load enables: stage 0 on ce, stage k on tap k*CE_DELAY-1.
    // NOTE: every signal written in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        w_en    = '0;
        w_en[0] = ce;
        for (int k = 1; k < NSTAGE; k++) begin
            w_en[k] = r_dl[k*CE_DELAY-1];
        end
    end

    generate
        if (NSTAGE > 1) begin : g_dl
            // Tap j holds the ce sampled j+1 edges ago.
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    r_dl <= '0;
                end else if (flush) begin
                    r_dl <= '0;
                end else begin
                    r_dl <= (r_dl << 1) | DL_W'(ce);
                end
            end
        end else begin : g_no_dl
            assign r_dl = '0;
        end

        // A ce seen 1..CE_DELAY-1 edges ago sits in taps 0..CE_DELAY-2.
        if (NSTAGE > 1 && CE_DELAY > 1) begin : g_recent
            assign w_recent = |r_dl[CE_DELAY-2:0];
        end else begin : g_no_recent
            assign w_recent = 1'b0;
        end
    endgenerate

    // Stage registers. They are few and narrow, and the outputs must read 0
    // after reset, so they are cleared rather than left as raw storage.
    // NOTE: non-blocking assignments make stage k take the pre-edge value of
    // stage k-1 even when both load on the same edge; blocking would let a
    // word fall through several stages in one cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NSTAGE; k++) begin
                r_stage[k] <= '0;
            end
        end else if (flush) begin
            for (int k = 0; k < NSTAGE; k++) begin
                r_stage[k] <= '0;
            end
        end else begin
            if (ce) begin
                r_stage[0] <= {hitmap_in, lcmap_in};
            end
            for (int k = 1; k < NSTAGE; k++) begin
                if (w_en[k]) begin
                    r_stage[k] <= r_stage[k-1];
                end
            end
        end
    end

    // out_valid is the final-stage enable delayed by the capture edge itself;
    // overrun latches until reset or flush.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_out_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_out_valid <= w_en[NSTAGE-1];
            r_overrun   <= r_overrun | (ce & w_recent);
        end
    end

    assign hitmap_out = r_stage[NSTAGE-1][W-1:NLAYER];
    assign lcmap_out  = r_stage[NSTAGE-1][NLAYER-1:0];
    assign out_valid  = r_out_valid;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_hitmap_lcmap_pipe.sv
// -----------------------------------------------------------------------------
// tb_hitmap_lcmap_pipe
//
// Directed bench for hitmap_lcmap_pipe. Three instances share clock and reset:
//   dut_a : defaults (NLAYER=5, NSTAGE=2, CE_DELAY=4)
//   dut_b : NLAYER=8, NSTAGE=3, CE_DELAY=2
//   dut_c : NLAYER=8, NSTAGE=1, CE_DELAY=4
// Edge numbering: "edge e" is the e-th rising edge of a scenario; inputs are
// set 1 time unit after an edge and outputs are sampled 1 time unit after.
// -----------------------------------------------------------------------------
module tb_hitmap_lcmap_pipe;

    logic       clock;
    logic       reset;

    logic       a_ce, a_flush, a_vld, a_ovr;
    logic [4:0] a_hit, a_lc, a_hout, a_lout;
    logic       b_ce, b_flush, b_vld, b_ovr;
    logic [7:0] b_hit, b_lc, b_hout, b_lout;
    logic       c_ce, c_flush, c_vld, c_ovr;
    logic [7:0] c_hit, c_lc, c_hout, c_lout;

    int n_tests = 0;
    int n_fail  = 0;

    hitmap_lcmap_pipe #(.NLAYER(5), .NSTAGE(2), .CE_DELAY(4)) dut_a (
        .clock(clock), .reset(reset), .ce(a_ce), .flush(a_flush),
        .hitmap_in(a_hit), .lcmap_in(a_lc),
        .hitmap_out(a_hout), .lcmap_out(a_lout),
        .out_valid(a_vld), .overrun(a_ovr)
    );

    hitmap_lcmap_pipe #(.NLAYER(8), .NSTAGE(3), .CE_DELAY(2)) dut_b (
        .clock(clock), .reset(reset), .ce(b_ce), .flush(b_flush),
        .hitmap_in(b_hit), .lcmap_in(b_lc),
        .hitmap_out(b_hout), .lcmap_out(b_lout),
        .out_valid(b_vld), .overrun(b_ovr)
    );

    hitmap_lcmap_pipe #(.NLAYER(8), .NSTAGE(1), .CE_DELAY(4)) dut_c (
        .clock(clock), .reset(reset), .ce(c_ce), .flush(c_flush),
        .hitmap_in(c_hit), .lcmap_in(c_lc),
        .hitmap_out(c_hout), .lcmap_out(c_lout),
        .out_valid(c_vld), .overrun(c_ovr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs;
        a_ce = 0; a_flush = 0; a_hit = '0; a_lc = '0;
        b_ce = 0; b_flush = 0; b_hit = '0; b_lc = '0;
        c_ce = 0; c_flush = 0; c_hit = '0; c_lc = '0;
    endtask

    // Reset for two edges, release between edges.
    task automatic apply_reset;
        idle_inputs();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset;
        idle_inputs();
        reset = 1'b0;
        #3;
        n_tests++;
        if ({a_hout, a_lout, a_vld, a_ovr} !== 12'h000) begin
            $display("FAIL reset_a got %h/%h v=%b o=%b exp 0", a_hout, a_lout, a_vld, a_ovr);
            n_fail++;
        end
        n_tests++;
        if ({b_hout, b_lout, b_vld, b_ovr} !== 18'h0) begin
            $display("FAIL reset_b got %h/%h v=%b o=%b exp 0", b_hout, b_lout, b_vld, b_ovr);
            n_fail++;
        end
        n_tests++;
        if ({c_hout, c_lout, c_vld, c_ovr} !== 18'h0) begin
            $display("FAIL reset_c got %h/%h v=%b o=%b exp 0", c_hout, c_lout, c_vld, c_ovr);
            n_fail++;
        end
        tick();
        tick();
        reset = 1'b1;
    endtask

    // Single word through the default pipe: output and pulse after edge 4.
    task automatic test_single;
        int pulses;
        logic [4:0] eh, el;
        logic ev;
        apply_reset();
        pulses = 0;
        a_ce = 1; a_hit = 5'h15; a_lc = 5'h0A;
        for (int e = 0; e < 8; e++) begin
            tick();
            if (e == 0) begin a_ce = 0; a_hit = '0; a_lc = '0; end
            eh = (e >= 4) ? 5'h15 : 5'h00;
            el = (e >= 4) ? 5'h0A : 5'h00;
            ev = (e == 4);
            n_tests++;
            if ({a_hout, a_lout} !== {eh, el}) begin
                $display("FAIL single_out e=%0d got %h/%h exp %h/%h", e, a_hout, a_lout, eh, el);
                n_fail++;
            end
            n_tests++;
            if (a_vld !== ev) begin
                $display("FAIL single_vld e=%0d got %b exp %b", e, a_vld, ev);
                n_fail++;
            end
            if (a_vld === 1'b1) pulses++;
        end
        n_tests++;
        if (pulses != 1) begin
            $display("FAIL single_pulses got %0d exp 1", pulses);
            n_fail++;
        end
        n_tests++;
        if (a_ovr !== 1'b0) begin
            $display("FAIL single_ovr got %b exp 0", a_ovr);
            n_fail++;
        end
    endtask

    // Strobes exactly CE_DELAY apart: legal, no overrun, three pulses.
    task automatic test_back_to_back;
        logic [4:0] in_h [3];
        logic [4:0] in_l [3];
        logic [4:0] eh, el;
        logic ev;
        int pulses;
        in_h[0] = 5'h01; in_h[1] = 5'h02; in_h[2] = 5'h04;
        in_l[0] = 5'h10; in_l[1] = 5'h08; in_l[2] = 5'h03;
        apply_reset();
        pulses = 0;
        for (int e = 0; e < 16; e++) begin
            if (e == 0 || e == 4 || e == 8) begin
                a_ce = 1; a_hit = in_h[e/4]; a_lc = in_l[e/4];
            end else begin
                a_ce = 0; a_hit = '0; a_lc = '0;
            end
            tick();
            if (e < 4) begin
                eh = 5'h00; el = 5'h00;
            end else begin
                eh = in_h[(e >= 12) ? 2 : (e / 4) - 1];
                el = in_l[(e >= 12) ? 2 : (e / 4) - 1];
            end
            ev = (e == 4 || e == 8 || e == 12);
            n_tests++;
            if ({a_hout, a_lout} !== {eh, el}) begin
                $display("FAIL b2b_out e=%0d got %h/%h exp %h/%h", e, a_hout, a_lout, eh, el);
                n_fail++;
            end
            n_tests++;
            if (a_vld !== ev || a_ovr !== 1'b0) begin
                $display("FAIL b2b_flags e=%0d got v=%b o=%b exp v=%b o=0", e, a_vld, a_ovr, ev);
                n_fail++;
            end
            if (a_vld === 1'b1) pulses++;
        end
        a_ce = 0;
        n_tests++;
        if (pulses != 3) begin
            $display("FAIL b2b_pulses got %0d exp 3", pulses);
            n_fail++;
        end
    endtask

    // ce at 0 and 2 sets overrun; a ce at 8 is still in flight when flush at
    // edge 10 clears everything, so it must never emerge.
    task automatic test_overrun;
        logic eo, ev;
        apply_reset();
        for (int e = 0; e < 22; e++) begin
            a_ce    = (e == 0 || e == 2 || e == 8);
            a_hit   = a_ce ? 5'h1B : 5'h00;
            a_lc    = a_ce ? 5'h06 : 5'h00;
            a_flush = (e == 10);
            tick();
            eo = (e >= 2 && e < 10);
            ev = (e == 4 || e == 6);
            n_tests++;
            if (a_ovr !== eo || a_vld !== ev) begin
                $display("FAIL ovr_flags e=%0d got o=%b v=%b exp o=%b v=%b", e, a_ovr, a_vld, eo, ev);
                n_fail++;
            end
            if (e >= 10) begin
                n_tests++;
                if ({a_hout, a_lout} !== 10'h000) begin
                    $display("FAIL ovr_flush_out e=%0d got %h/%h exp 00/00", e, a_hout, a_lout);
                    n_fail++;
                end
            end
        end
        a_ce = 0; a_flush = 0;
    endtask

    // flush wins over ce: the word is dropped and leaves nothing in the delay
    // line, so a ce two edges later neither overruns nor is disturbed.
    task automatic test_flush_ce;
        logic [4:0] eh, el;
        logic ev;
        apply_reset();
        for (int e = 0; e < 10; e++) begin
            a_flush = (e == 0);
            a_ce    = (e == 0 || e == 2);
            a_hit   = (e == 0) ? 5'h1F : (e == 2) ? 5'h03 : 5'h00;
            a_lc    = (e == 0) ? 5'h1F : (e == 2) ? 5'h0C : 5'h00;
            tick();
            eh = (e >= 6) ? 5'h03 : 5'h00;
            el = (e >= 6) ? 5'h0C : 5'h00;
            ev = (e == 6);
            n_tests++;
            if ({a_hout, a_lout} !== {eh, el} || a_vld !== ev || a_ovr !== 1'b0) begin
                $display("FAIL flush_ce e=%0d got %h/%h v=%b o=%b exp %h/%h v=%b o=0",
                         e, a_hout, a_lout, a_vld, a_ovr, eh, el, ev);
                n_fail++;
            end
        end
        a_ce = 0; a_flush = 0;
    endtask

    // Async reset mid-cycle while a pulse is shown and a word is in flight.
    task automatic test_async_reset;
        logic [4:0] eh, el;
        logic ev;
        apply_reset();
        for (int e = 0; e < 5; e++) begin
            a_ce  = (e == 0 || e == 2);
            a_hit = a_ce ? 5'h11 : 5'h00;
            a_lc  = a_ce ? 5'h0E : 5'h00;
            tick();
        end
        a_ce = 0; a_hit = '0; a_lc = '0;
        n_tests++;
        if (a_vld !== 1'b1 || a_ovr !== 1'b1) begin
            $display("FAIL areset_pre got v=%b o=%b exp v=1 o=1", a_vld, a_ovr);
            n_fail++;
        end
        #3 reset = 1'b0;
        #1;
        n_tests++;
        if ({a_hout, a_lout, a_vld, a_ovr} !== 12'h000) begin
            $display("FAIL areset_now got %h/%h v=%b o=%b exp 0", a_hout, a_lout, a_vld, a_ovr);
            n_fail++;
        end
        tick();
        tick();
        #2 reset = 1'b1;
        // First edge after release must accept a new ce; nothing else emerges.
        a_ce = 1; a_hit = 5'h07; a_lc = 5'h18;
        for (int r = 0; r < 10; r++) begin
            tick();
            if (r == 0) begin a_ce = 0; a_hit = '0; a_lc = '0; end
            eh = (r >= 4) ? 5'h07 : 5'h00;
            el = (r >= 4) ? 5'h18 : 5'h00;
            ev = (r == 4);
            n_tests++;
            if ({a_hout, a_lout} !== {eh, el} || a_vld !== ev || a_ovr !== 1'b0) begin
                $display("FAIL areset_post r=%0d got %h/%h v=%b o=%b exp %h/%h v=%b o=0",
                         r, a_hout, a_lout, a_vld, a_ovr, eh, el, ev);
                n_fail++;
            end
        end
    endtask

    // Three stages, CE_DELAY=2: latency 4; ce one edge apart overruns.
    task automatic test_deep;
        logic [7:0] eh, el;
        logic ev, eo;
        apply_reset();
        for (int e = 0; e < 13; e++) begin
            b_ce  = (e == 0 || e == 10 || e == 11);
            b_hit = (e == 0) ? 8'hA5 : (b_ce ? 8'hFF : 8'h00);
            b_lc  = (e == 0) ? 8'h3C : (b_ce ? 8'hFF : 8'h00);
            tick();
            eh = (e >= 4) ? 8'hA5 : 8'h00;
            el = (e >= 4) ? 8'h3C : 8'h00;
            ev = (e == 4);
            eo = (e >= 11);
            n_tests++;
            if ({b_hout, b_lout} !== {eh, el} || b_vld !== ev || b_ovr !== eo) begin
                $display("FAIL deep e=%0d got %h/%h v=%b o=%b exp %h/%h v=%b o=%b",
                         e, b_hout, b_lout, b_vld, b_ovr, eh, el, ev, eo);
                n_fail++;
            end
        end
        b_ce = 0; b_hit = '0; b_lc = '0;
    endtask

    // Single stage: output and pulse right after the ce edge; never overruns.
    task automatic test_single_stage;
        logic [7:0] eh, el;
        logic ev;
        apply_reset();
        for (int e = 0; e < 6; e++) begin
            c_ce  = (e == 0 || e == 2 || e == 3);
            c_hit = (e == 0) ? 8'h5A : (e == 2) ? 8'h11 : (e == 3) ? 8'h22 : 8'h00;
            c_lc  = (e == 0) ? 8'hC3 : (e == 2) ? 8'h44 : (e == 3) ? 8'h88 : 8'h00;
            tick();
            eh = (e <= 1) ? 8'h5A : (e == 2) ? 8'h11 : 8'h22;
            el = (e <= 1) ? 8'hC3 : (e == 2) ? 8'h44 : 8'h88;
            ev = (e == 0 || e == 2 || e == 3);
            n_tests++;
            if ({c_hout, c_lout} !== {eh, el} || c_vld !== ev || c_ovr !== 1'b0) begin
                $display("FAIL one_stage e=%0d got %h/%h v=%b o=%b exp %h/%h v=%b o=0",
                         e, c_hout, c_lout, c_vld, c_ovr, eh, el, ev);
                n_fail++;
            end
        end
        c_ce = 0; c_hit = '0; c_lc = '0;
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();
        test_reset();
        test_single();
        test_back_to_back();
        test_overrun();
        test_flush_ce();
        test_async_reset();
        test_deep();
        test_single_stage();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "bench timeout");
    end

endmodule
